icache_refill_ctrl: RTL and testbench

- Consumer end of the I-cache compare-stage pipeline register.
- Takes the registered lookup result (valid, hit, address, data):
  - hit: returns the instruction word to fetch.
  - miss: stalls fetch, issues a line read to memory, streams the returned words into the cache data/tag arrays, then returns the missed word.
- Sits between the compare-stage register, the fetch stage and the memory request/response port.

---
 rtl/icache_refill_ctrl_if.sv | 38 +++
 rtl/icache_refill_ctrl.sv | 138 +++++++++++++
 tb/tb_icache_refill_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_if.sv
// rtl/icache_refill_ctrl_if.sv - lookup, fetch, memory and fill signals of the I-cache refill controller
interface icache_refill_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              request_valid;
    logic              hit;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              inst_valid;
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst_data;
    logic              stall;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_data;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [31:0]       fill_data;
    logic              fill_done;

    modport master (
        input  request_valid, hit, r_addr, r_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output inst_valid, inst_addr, inst_data, stall,
        output mem_req_valid, mem_req_addr,
        output fill_we, fill_addr, fill_data, fill_done
    );

    modport slave (
        output request_valid, hit, r_addr, r_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  inst_valid, inst_addr, inst_data, stall,
        input  mem_req_valid, mem_req_addr,
        input  fill_we, fill_addr, fill_data, fill_done
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - I-cache hit return and line refill controller (option: CRITICAL_WORD_FORWARD_EN)
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    icache_refill_ctrl_if.master bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t            state, state_d;
    logic [IDX_W-1:0]  count, count_d;
    logic [ADDR_W-1:0] miss_addr, miss_addr_d;
    logic [ADDR_W-1:0] base, base_d;
    logic [31:0]       crit_word, crit_word_d;
    logic [ADDR_W-1:0] line_base;

    logic              inst_valid_d, stall_d, mem_req_valid_d, fill_we_d, fill_done_d;
    logic [ADDR_W-1:0] inst_addr_d, mem_req_addr_d, fill_addr_d;
    logic [31:0]       inst_data_d, fill_data_d;

    assign line_base = {bus.r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Outputs are computed one cycle ahead and registered alongside the state.
    always_comb begin
        state_d         = state;
        count_d         = count;
        miss_addr_d     = miss_addr;
        base_d          = base;
        crit_word_d     = crit_word;
        inst_valid_d    = 1'b0;
        inst_addr_d     = '0;
        inst_data_d     = '0;
        stall_d         = 1'b0;
        mem_req_valid_d = 1'b0;
        mem_req_addr_d  = '0;
        fill_we_d       = 1'b0;
        fill_addr_d     = '0;
        fill_data_d     = '0;
        fill_done_d     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.request_valid && bus.hit) begin
                    inst_valid_d = 1'b1;
                    inst_addr_d  = bus.r_addr;
                    inst_data_d  = bus.r_data;
                end else if (bus.request_valid) begin
                    miss_addr_d     = bus.r_addr;
                    base_d          = line_base;
                    stall_d         = 1'b1;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = line_base;
                    state_d         = REQ;
                end
            end
            REQ: begin
                stall_d = 1'b1;
                if (bus.mem_req_ready) begin
                    count_d = '0;
                    state_d = FILL;
                end else begin
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = base;
                end
            end
            FILL: begin
                stall_d = 1'b1;
                if (bus.mem_resp_valid) begin
                    fill_we_d   = 1'b1;
                    fill_addr_d = base + ADDR_W'({count, 2'b00});
                    fill_data_d = bus.mem_resp_data;
                    count_d     = count + IDX_W'(1);
                    if (count == miss_addr[OFF_W-1:2]) begin
                        crit_word_d = bus.mem_resp_data;
`ifdef CRITICAL_WORD_FORWARD_EN
                        inst_valid_d = 1'b1;
                        inst_addr_d  = miss_addr;
                        inst_data_d  = bus.mem_resp_data;
`endif
                    end
                    if (count == LAST_BEAT) state_d = DONE;
                end
            end
            DONE: begin
                fill_done_d = 1'b1;
`ifdef CRITICAL_WORD_FORWARD_EN
`else
                inst_valid_d = 1'b1;
                inst_addr_d  = miss_addr;
                inst_data_d  = crit_word;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state             <= IDLE;
            count             <= '0;
            miss_addr         <= '0;
            base              <= '0;
            crit_word         <= '0;
            bus.inst_valid    <= 1'b0;
            bus.inst_addr     <= '0;
            bus.inst_data     <= '0;
            bus.stall         <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.fill_we       <= 1'b0;
            bus.fill_addr     <= '0;
            bus.fill_data     <= '0;
            bus.fill_done     <= 1'b0;
        end else begin
            state             <= state_d;
            count             <= count_d;
            miss_addr         <= miss_addr_d;
            base              <= base_d;
            crit_word         <= crit_word_d;
            bus.inst_valid    <= inst_valid_d;
            bus.inst_addr     <= inst_addr_d;
            bus.inst_data     <= inst_data_d;
            bus.stall         <= stall_d;
            bus.mem_req_valid <= mem_req_valid_d;
            bus.mem_req_addr  <= mem_req_addr_d;
            bus.fill_we       <= fill_we_d;
            bus.fill_addr     <= fill_addr_d;
            bus.fill_data     <= fill_data_d;
            bus.fill_done     <= fill_done_d;
        end
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed and randomized checks of icache_refill_ctrl against a transaction model
module tb_icache_refill_ctrl;
    localparam int LW  = 4;
    localparam int AW  = 32;
    localparam int OFF = $clog2(LW) + 2;
`ifdef CRITICAL_WORD_FORWARD_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    icache_refill_ctrl_if #(.ADDR_W(AW)) bus ();
    icache_refill_ctrl #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] line_w [LW];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.request_valid  = 1'b0;
        bus.hit            = 1'b0;
        bus.r_addr         = '0;
        bus.r_data         = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic noisy_lookup(input bit noise);
        bus.request_valid = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.hit           = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.r_addr        = noise ? $urandom : bus.r_addr;
        bus.r_data        = $urandom;
    endtask

    task automatic do_hit(input logic [AW-1:0] a, input logic [31:0] d);
        bus.request_valid = 1'b1;
        bus.hit           = 1'b1;
        bus.r_addr        = a;
        bus.r_data        = d;
        tick();
        bus.request_valid = 1'b0;
        bus.hit           = 1'b0;
        chk("hit_valid", bus.inst_valid, 1);
        chk("hit_addr", bus.inst_addr, a);
        chk("hit_data", bus.inst_data, d);
        chk("hit_stall", bus.stall, 0);
        chk("hit_memreq", bus.mem_req_valid, 0);
    endtask

    // Full miss: request held for dly cycles, gap2 idle cycles before beat 2, random gaps elsewhere.
    task automatic do_miss(input logic [AW-1:0] a, input int dly, input int gap2,
                           input int gap_max, input bit noise);
        logic [AW-1:0] base;
        int idx;
        int gaps;
        base = a;
        base[OFF-1:0] = '0;
        idx = int'(a[OFF-1:2]);
        bus.request_valid = 1'b1;
        bus.hit           = 1'b0;
        bus.r_addr        = a;
        tick();
        chk("miss_stall", bus.stall, 1);
        chk("miss_memreq", bus.mem_req_valid, 1);
        chk("miss_reqaddr", bus.mem_req_addr, base);
        chk("miss_inst", bus.inst_valid, 0);
        for (int d = 0; d < dly; d++) begin
            noisy_lookup(noise);
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mem_resp_data  = $urandom;
            tick();
            chk("req_hold_valid", bus.mem_req_valid, 1);
            chk("req_hold_addr", bus.mem_req_addr, base);
            chk("req_fill_we", bus.fill_we, 0);
            chk("req_inst", bus.inst_valid, 0);
        end
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b0;
        chk("req_drop", bus.mem_req_valid, 0);
        chk("req_stall", bus.stall, 1);
        for (int i = 0; i < LW; i++) begin
            gaps = (i == 2) ? gap2 : $urandom_range(0, gap_max);
            for (int g = 0; g < gaps; g++) begin
                noisy_lookup(noise);
                bus.mem_resp_valid = 1'b0;
                tick();
                chk("gap_we", bus.fill_we, 0);
                chk("gap_inst", bus.inst_valid, 0);
                chk("gap_stall", bus.stall, 1);
            end
            noisy_lookup(noise);
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = line_w[i];
            tick();
            bus.mem_resp_valid = 1'b0;
            chk("beat_we", bus.fill_we, 1);
            chk("beat_addr", bus.fill_addr, base + AW'(4 * i));
            chk("beat_data", bus.fill_data, line_w[i]);
            chk("beat_inst", bus.inst_valid, CWF && (i == idx));
            if (i == idx) begin
                chk("fwd_addr", bus.inst_valid ? bus.inst_addr : a, a);
                chk("fwd_data", bus.inst_valid ? bus.inst_data : line_w[i], line_w[i]);
            end
            chk("beat_done", bus.fill_done, 0);
            chk("beat_stall", bus.stall, 1);
        end
        bus.request_valid = 1'b0;
        bus.hit           = 1'b0;
        tick();
        chk("done_pulse", bus.fill_done, 1);
        chk("done_inst", bus.inst_valid, !CWF);
        chk("done_addr", bus.inst_valid ? bus.inst_addr : a, a);
        chk("done_data", bus.inst_valid ? bus.inst_data : line_w[idx], line_w[idx]);
        chk("done_stall", bus.stall, 0);
        chk("done_we", bus.fill_we, 0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        idle_inputs();
        tick();
        tick();
        chk("rst_inst", bus.inst_valid, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_memreq", bus.mem_req_valid, 0);
        chk("rst_fill", {bus.fill_we, bus.fill_done}, 0);
        RESET = 1'b1;
        tick();
        chk("idle_inst", bus.inst_valid, 0);

        do_hit(32'h100, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) do_hit(32'h200 + AW'(4 * i), 32'h5000 + i);
        tick();
        chk("hit_pulse_end", bus.inst_valid, 0);

        for (int i = 0; i < LW; i++) line_w[i] = 32'hA0 + i;
        do_miss(32'h1008, 3, 0, 0, 1'b0);
        do_hit(32'h300, 32'h12345678);
        do_miss(32'h1008, 0, 3, 0, 1'b0);
        do_miss(32'h1004, 1, 0, 0, 1'b0);
        do_miss(32'h2000, 2, 1, 2, 1'b1);
        do_miss(32'h300C, 0, 0, 0, 1'b1);

        // Reset in the middle of a refill: no fill_done, outputs cleared immediately.
        do_hit(32'h40, 32'h40);
        bus.request_valid = 1'b1;
        bus.r_addr        = 32'h4004;
        tick();
        bus.request_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 32'hB0 + i;
            tick();
        end
        chk("pre_rst_we", bus.fill_we, 1);
        #2 RESET = 1'b0;
        #1;
        chk("arst_outs", {bus.inst_valid, bus.stall, bus.mem_req_valid, bus.fill_we, bus.fill_done}, 0);
        chk("arst_data", {bus.fill_addr, bus.fill_data}, 0);
        tick();
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_resp_valid = 1'b1;
            tick();
            chk("post_rst_done", bus.fill_done, 0);
            chk("post_rst_we", bus.fill_we, 0);
        end
        bus.mem_resp_valid = 1'b0;
        do_hit(32'h500, 32'hCAFEF00D);

        for (int t = 0; t < 30; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                do_hit(ra, $urandom);
            end else begin
                for (int i = 0; i < LW; i++) line_w[i] = $urandom;
                do_miss(ra, $urandom_range(0, 3), $urandom_range(0, 2), 2, 1'($urandom_range(0, 1)));
            end
        end

        idle_inputs();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
